// File: rtl/id_exe_unpack_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_exe_unpack_stage
// Description : Consumer end of the ID/EXE bundle. It buffers bundles in a
//               small FIFO, feeds the head to the external ALU, and registers
//               the result into the EXE/MEM bundle. The optional performance
//               counters are enabled with the EXE_PERF_CNT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module id_exe_unpack_stage #(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [59:0] id_exe_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [15:0] alu_op_a,
    output logic [15:0] alu_op_b,
    output logic [3:0]  alu_ctrl,
    input  logic [15:0] alu_result,
    output logic [38:0] exe_mem_out,
    output logic        out_valid,
    input  logic        out_ready
`ifdef EXE_PERF_CNT_EN
    ,
    output logic [15:0] issue_count,
    output logic [15:0] stall_count
`endif
);

    localparam logic [PTR_W:0]   c_depth   = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   c_cnt_one = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

    logic [59:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_out_valid;
    logic [38:0]      r_exe_mem_out;

    logic [59:0]      w_head;
    logic             w_head_valid;
    logic             w_in_ready;
    logic             w_enq;
    logic             w_issue;

    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_valid = (r_count != '0);
    // in_ready comes from the registered count only, so a full FIFO refuses
    // a bundle even when the head issues on the same edge.
    assign w_in_ready   = (r_count < c_depth);
    assign w_enq        = in_valid && w_in_ready && !flush;
    assign w_issue      = w_head_valid && (!r_out_valid || out_ready) && !flush;

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign exe_mem_out = r_exe_mem_out;

    assign alu_op_a = w_head_valid ? w_head[31:16] : 16'h0000;
    assign alu_op_b = !w_head_valid ? 16'h0000 :
                      (w_head[43] ? w_head[59:44] : w_head[15:0]);
    assign alu_ctrl = w_head_valid ? w_head[37:34] : 4'h0;

    // Storage carries no reset; entries are only observed while counted valid.
    always_ff @(negedge clock) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= id_exe_in;
        end
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_enq && !w_issue) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_enq && w_issue) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_exe_mem_out <= '0;
        end else if (flush) begin
            r_out_valid   <= 1'b0;
        end else if (w_issue) begin
            r_out_valid   <= 1'b1;
            r_exe_mem_out <= {alu_result, w_head[15:0], w_head[42:39],
                              w_head[38], w_head[33], w_head[32]};
        end else if (out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

`ifdef EXE_PERF_CNT_EN
    logic [15:0] r_issue_count;
    logic [15:0] r_stall_count;

    // Counters survive flush; only reset clears them.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_issue_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_issue) begin
                r_issue_count <= r_issue_count + 16'd1;
            end
            if (w_head_valid && !w_issue) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign issue_count = r_issue_count;
    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_exe_unpack_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_exe_unpack_stage
// Description : Self-checking bench for id_exe_unpack_stage with an ALU model
//               and an expected-output queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_exe_unpack_stage;

    logic        clock;
    logic        reset;
    logic [59:0] id_exe_in;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [15:0] alu_op_a;
    logic [15:0] alu_op_b;
    logic [3:0]  alu_ctrl;
    logic [15:0] alu_result;
    logic [38:0] exe_mem_out;
    logic        out_valid;
    logic        out_ready;
`ifdef EXE_PERF_CNT_EN
    logic [15:0] issue_count;
    logic [15:0] stall_count;
`endif

    id_exe_unpack_stage #(.DEPTH(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .id_exe_in   (id_exe_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .alu_op_a    (alu_op_a),
        .alu_op_b    (alu_op_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .exe_mem_out (exe_mem_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
`ifdef EXE_PERF_CNT_EN
        ,
        .issue_count (issue_count),
        .stall_count (stall_count)
`endif
    );

    typedef struct {
        logic [15:0] inm;
        logic        sel;
        logic [3:0]  dest;
        logic        wb;
        logic [3:0]  ctrl;
        logic        wr;
        logic        rd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_op_b;
        logic [15:0] exp_res;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    int          run_len  = 0;
    int          max_run  = 0;
    logic [38:0] exp_q[$];
    logic [38:0] m_exp;
    vec_t        vecs [7];
    vec_t        rv;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] c);
        case (c)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h6:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_op_a, alu_op_b, alu_ctrl);

    function automatic logic [59:0] pack_in(input vec_t v);
        return {v.inm, v.sel, v.dest, v.wb, v.ctrl, v.wr, v.rd, v.a, v.b};
    endfunction

    function automatic logic [38:0] pack_out(input vec_t v);
        return {v.exp_res, v.b, v.dest, v.wb, v.wr, v.rd};
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.inm  = 16'($urandom);
        v.sel  = 1'($urandom);
        v.dest = 4'($urandom);
        v.wb   = 1'($urandom);
        v.ctrl = 4'($urandom);
        v.wr   = 1'($urandom);
        v.rd   = 1'($urandom);
        v.a    = 16'($urandom);
        v.b    = 16'($urandom);
        v.exp_op_b = v.sel ? v.inm : v.b;
        v.exp_res  = alu_model(v.a, v.exp_op_b, v.ctrl);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Drives one bundle from posedge+1 and pushes its expected output once
    // in_ready shows it will be taken on the coming falling edge.
    task automatic send(input vec_t v);
        int waited = 0;
        @(posedge clock); #1;
        id_exe_in = pack_in(v);
        in_valid  = 1'b1;
        #3;
        while (!in_ready && waited < 50) begin
            @(posedge clock); #4;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=in_ready_low exp=accept");
        end else begin
            exp_q.push_back(pack_out(v));
        end
    endtask

    task automatic idle();
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clock); #4;
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Output monitor: sampled just before each falling edge.
    always begin
        @(posedge clock); #3;
        if (!reset) begin
            if (out_valid) run_len++;
            else run_len = 0;
            if (run_len > max_run) max_run = run_len;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected got=%h exp=none", exe_mem_out);
                end else begin
                    m_exp = exp_q.pop_front();
                    check("exe_mem_out", 64'(exe_mem_out), 64'(m_exp));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        id_exe_in = '0;

        vecs[0] = '{16'h0005, 1'b1, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0005, 16'h0015};
        vecs[1] = '{16'h1234, 1'b0, 4'h7, 1'b0, 4'h2, 1'b1, 1'b0, 16'h0001, 16'hBEEF, 16'hBEEF, 16'hBEF0};
        vecs[2] = '{16'hFFFF, 1'b1, 4'hF, 1'b1, 4'h6, 1'b0, 1'b1, 16'h0000, 16'h00AA, 16'hFFFF, 16'h0001};
        vecs[3] = '{16'h0000, 1'b0, 4'hA, 1'b1, 4'h0, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, 16'hFF00, 16'hF000};
        vecs[4] = '{16'h8000, 1'b1, 4'h3, 1'b0, 4'h1, 1'b0, 1'b0, 16'h0F0F, 16'h1111, 16'h8000, 16'h8F0F};
        vecs[5] = '{16'h00FF, 1'b0, 4'h1, 1'b1, 4'h4, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[6] = '{16'h0001, 1'b1, 4'hC, 1'b1, 4'h2, 1'b0, 1'b1, 16'hFFFF, 16'h5555, 16'h0001, 16'h0000};

        // Reset state
        @(posedge clock); #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_exe_mem_out", 64'(exe_mem_out), 64'd0);
        check("rst_alu_op_a", 64'(alu_op_a), 64'd0);
        #1 reset = 1'b0;
        #1 check("rst_in_ready", 64'(in_ready), 64'd1);

        // Table of single bundles
        for (int i = 0; i < 7; i++) begin
            send(vecs[i]);
            @(posedge clock); #1;
            in_valid = 1'b0;
            #2;
            check("vec_alu_op_a", 64'(alu_op_a), 64'(vecs[i].a));
            check("vec_alu_op_b", 64'(alu_op_b), 64'(vecs[i].exp_op_b));
            check("vec_alu_ctrl", 64'(alu_ctrl), 64'(vecs[i].ctrl));
            drain();
        end
        check("vec1_low7", 64'(pack_out(vecs[1]) & 39'h7F), 64'b0111010);

        // Backpressure: three bundles fill the output register and the FIFO
        @(posedge clock); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rv = rand_vec();
            send(rv);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            in_valid = 1'b0;
            #3;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_hold", 64'(exe_mem_out), 64'(exp_q[0]));
        end
        // Release while offering a fourth bundle: refused on the full edge
        rv = rand_vec();
        @(posedge clock); #1;
        out_ready = 1'b1;
        id_exe_in = pack_in(rv);
        in_valid  = 1'b1;
        #3;
        check("full_refuse", 64'(in_ready), 64'd0);
        send(rv);
        idle();
        drain();

        // Back-to-back stream of 8
        repeat (2) idle();
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            rv = rand_vec();
            send(rv);
        end
        idle();
        drain();
        repeat (2) idle();
        check("stream_run", 64'(max_run), 64'd8);

        // Flush with two buffered and out_valid set; concurrent enqueue dropped
        @(posedge clock); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rv = rand_vec();
            send(rv);
        end
        rv = rand_vec();
        rv.a = 16'hA5A5;
        @(posedge clock); #1;
        id_exe_in = pack_in(rv);
        in_valid  = 1'b1;
        flush     = 1'b1;
        exp_q.delete();
        @(posedge clock); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        #3;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_empty_op_a", 64'(alu_op_a), 64'd0);
        out_ready = 1'b1;
        rv = rand_vec();
        send(rv);
        idle();
        drain();

        // Asynchronous reset between edges mid-stream
        for (int i = 0; i < 2; i++) begin
            rv = rand_vec();
            send(rv);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_exe_mem_out", 64'(exe_mem_out), 64'd0);
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_op_a_empty", 64'(alu_op_a), 64'd0);
        send(vecs[4]);
        idle();
        drain();

        repeat (2) idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
